// File: rtl/bram_test_pkg.sv
// Shared types and the expected-data rule for the BRAM self-test sequencer.
package bram_test_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        PAT_INC   = 2'd0,
        PAT_WALK  = 2'd1,
        PAT_CHK   = 2'd2,
        PAT_CONST = 2'd3
    } pattern_t;

    localparam int MAX_DW = 32;
    localparam int MAX_AW = 16;

    // Works at a fixed maximum width; dw selects the live data width so the
    // rotate wraps at the real word boundary.
    function automatic logic [MAX_DW-1:0] expected_data(
        input pattern_t              pattern,
        input logic [MAX_DW-1:0]     seed,
        input logic [MAX_AW-1:0]     addr,
        input int unsigned           dw
    );
        logic [2*MAX_DW-1:0] mask;
        logic [2*MAX_DW-1:0] s;
        logic [2*MAX_DW-1:0] r_s;
        int unsigned         r;
        mask = (64'd1 << dw) - 64'd1;
        s    = {{MAX_DW{1'b0}}, seed} & mask;
        r    = 32'(addr) % dw;
        case (pattern)
            PAT_INC:  r_s = (s + {{(2*MAX_DW-MAX_AW){1'b0}}, addr}) & mask;
            PAT_WALK: r_s = ((s << r) | (s >> (dw - r))) & mask;
            PAT_CHK:  r_s = addr[0] ? (~s & mask) : s;
            default:  r_s = s;
        endcase
        return r_s[MAX_DW-1:0];
    endfunction

endpackage

// File: rtl/bram_test_pattern_gen.sv
// Combinational expected-data generator shared by the write and compare paths.
module bram_test_pattern_gen
    import bram_test_pkg::*;
#(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
) (
    input  pattern_t            pattern,
    input  logic [DATA_W-1:0]   seed,
    input  logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   data
);

    assign data = DATA_W'(expected_data(pattern, MAX_DW'(seed), MAX_AW'(addr), DATA_W));

endmodule

// File: rtl/bram_test_ctrl.sv
// BRAM self-test sequencer: write pattern, read back, compare; arbitrates the
// single BRAM port with a manual requester whenever no run is in progress.
module bram_test_ctrl
    import bram_test_pkg::*;
#(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        pattern_sel,
    input  logic [DATA_W-1:0] seed,
    input  logic              manual_req,
    input  logic              manual_we,
    input  logic [ADDR_W-1:0] manual_addr,
    input  logic [DATA_W-1:0] manual_din,
    output logic              manual_gnt,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cnt;
    pattern_t          pat_q;
    logic [DATA_W-1:0] seed_q;
    logic [ADDR_W-1:0] rd_addr_pipe [RD_LAT];
    logic [RD_LAT-1:0] rd_vld_pipe;
    logic [ADDR_W-1:0] pg_addr;
    logic [ADDR_W-1:0] cmp_addr;
    logic [DATA_W-1:0] exp_data;
    logic              cmp_vld;
    logic              mismatch;
    logic              start_run;
    logic              cnt_last;
    logic              drain_last;

    assign busy       = (state == S_WRITE) || (state == S_READ) || (state == S_DRAIN);
    assign done       = (state == S_DONE);
    assign pass       = done && (err_cnt == 8'd0);
    assign manual_gnt = !busy;
    assign start_run  = ((state == S_IDLE) || (state == S_DONE)) && start;
    assign cnt_last   = &cnt;
    assign drain_last = (cnt == ADDR_W'(RD_LAT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: if (start)      state_next = S_WRITE;
            S_WRITE:        if (cnt_last)   state_next = S_READ;
            S_READ:         if (cnt_last)   state_next = S_DRAIN;
            S_DRAIN:        if (drain_last) state_next = S_DONE;
            default:                        state_next = S_IDLE;
        endcase
    end

    // One counter serves all three phases: it wraps N-1 -> 0 at each
    // WRITE/READ boundary and restarts from 0 for DRAIN.
    always_ff @(posedge clk) begin
        if (!rst_n)    cnt <= '0;
        else if (busy) cnt <= cnt + ADDR_W'(1);
        else           cnt <= '0;
    end

    always_ff @(posedge clk) begin
        if (start_run) begin
            pat_q  <= pattern_t'(pattern_sel);
            seed_q <= seed;
        end
    end

    // Read-address delay pipe, aligned to the BRAM read latency
    always_ff @(posedge clk) begin
        rd_addr_pipe[0] <= cnt;
        for (int i = 1; i < RD_LAT; i++) rd_addr_pipe[i] <= rd_addr_pipe[i-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_vld_pipe <= '0;
        end else begin
            rd_vld_pipe[0] <= (state == S_READ);
            for (int i = 1; i < RD_LAT; i++) rd_vld_pipe[i] <= rd_vld_pipe[i-1];
        end
    end

    assign cmp_vld  = rd_vld_pipe[RD_LAT-1];
    assign cmp_addr = rd_addr_pipe[RD_LAT-1];
    assign pg_addr  = (state == S_WRITE) ? cnt : cmp_addr;

    bram_test_pattern_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_pattern_gen (
        .pattern (pat_q),
        .seed    (seed_q),
        .addr    (pg_addr),
        .data    (exp_data)
    );

    assign mismatch = cmp_vld && (bram_dout != exp_data);

    // A zero count means no mismatch yet in this run, so it gates the capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt        <= 8'd0;
            first_err_addr <= '0;
        end else if (start_run) begin
            err_cnt        <= 8'd0;
            first_err_addr <= '0;
        end else if (mismatch) begin
            if (err_cnt == 8'd0)  first_err_addr <= cmp_addr;
            if (err_cnt != 8'hFF) err_cnt        <= err_cnt + 8'd1;
        end
    end

    always_comb begin
        bram_we   = manual_req && manual_we;
        bram_addr = manual_addr;
        bram_din  = manual_din;
        if (busy) begin
            bram_we   = (state == S_WRITE);
            bram_addr = cnt;
            bram_din  = exp_data;
        end
    end

endmodule
